// File: rtl/color_adjust_pkg.sv
// Shared constants, types and helpers for the color_adjust pixel stage.
package color_adjust_pkg;

  localparam int CH_W_DEF      = 8;
  localparam int NCH_DEF       = 3;
  localparam int GAIN_W_DEF    = 8;
  localparam int GAIN_FRAC_DEF = 2;
  localparam int OFF_W_DEF     = 9;

  typedef struct packed {
    logic valid;
    logic sof;
  } stage_vld_t;

  function automatic int unity_gain(input int frac);
    return 1 << frac;
  endfunction

  // Saturate a signed value into the range [0, 2^ch_w-1].
  function automatic logic [31:0] clamp_ch(input logic signed [31:0] v, input int ch_w);
    logic signed [31:0] max_v;
    max_v = (32'sd1 <<< ch_w) - 32'sd1;
    if (v[31]) return '0;
    else if (v > max_v) return max_v;
    else return v;
  endfunction

endpackage

// File: rtl/color_adjust_channel.sv
// One colour channel: stage 1 multiplies by gain, stage 2 shifts, adds offset and clamps.
module channel_adjust
  import color_adjust_pkg::*;
#(
  parameter int CH_W      = CH_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int OFF_W     = OFF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              s1_valid,
  input  logic [CH_W-1:0]   pix,
  input  logic [GAIN_W-1:0] gain,
  input  logic [OFF_W-1:0]  offset,
  output logic [CH_W-1:0]   out,
  output logic              clamped
);

  localparam int PW = CH_W + GAIN_W;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 << CH_W) - 1);

  logic [PW-1:0]         prod_q;
  logic [OFF_W-1:0]      off_q;
  logic [PW-1:0]         shifted;
  logic signed [SW-1:0]  sum;
  logic signed [31:0]    sum32;
  logic                  is_clamp;

  // The offset travels with the pixel so it matches the gain used at stage 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      off_q  <= '0;
    end else if (in_valid) begin
      prod_q <= PW'(pix) * PW'(gain);
      off_q  <= offset;
    end
  end

  always_comb begin
    shifted  = prod_q >> GAIN_FRAC;
    sum      = $signed({1'b0, shifted}) + SW'($signed(off_q));
    sum32    = 32'(sum);
    is_clamp = sum[SW-1] || (sum > MAX_V);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out     <= '0;
      clamped <= 1'b0;
    end else if (s1_valid) begin
      out     <= CH_W'(clamp_ch(sum32, CH_W));
      clamped <= is_clamp;
    end
  end

endmodule

// File: rtl/color_adjust.sv
// Per-channel gain/offset adjust with frame-boundary config shadowing.
// Optional SAT_STATS_EN adds a per-frame clamp counter on sat_count.
module color_adjust
  import color_adjust_pkg::*;
#(
  parameter int CH_W      = CH_W_DEF,
  parameter int NCH       = NCH_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int GAIN_FRAC = GAIN_FRAC_DEF,
  parameter int OFF_W     = OFF_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH*CH_W-1:0] pix_in,
  input  logic                pix_valid_in,
  input  logic                pix_sof_in,
  input  logic [GAIN_W-1:0]   cfg_gain,
  input  logic [OFF_W-1:0]    cfg_offset,
  input  logic                cfg_wr,
  output logic [NCH*CH_W-1:0] pix_out,
  output logic                pix_valid_out,
  output logic                pix_sof_out,
  output logic                cfg_pending
`ifdef SAT_STATS_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_FRAC));

  // Handshake: pix_valid_in qualifies pix_in and pix_sof_in for one cycle; there
  // is no ready, the pipe never stalls, and pix_valid_out marks pix_out/pix_sof_out.

  logic [GAIN_W-1:0] act_gain, pend_gain, use_gain;
  logic [OFF_W-1:0]  act_off, pend_off, use_off;
  logic              apply;
  stage_vld_t        s1, s2;
  logic [NCH-1:0]    clamp_flags;

  assign apply    = pix_valid_in && pix_sof_in && cfg_pending;
  assign use_gain = apply ? pend_gain : act_gain;
  assign use_off  = apply ? pend_off  : act_off;

  // A write on the same cycle as an applying sof lands in pending for the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_gain    <= UNITY;
      act_off     <= '0;
      pend_gain   <= UNITY;
      pend_off    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (apply) begin
        act_gain <= pend_gain;
        act_off  <= pend_off;
      end
      if (cfg_wr) begin
        pend_gain   <= cfg_gain;
        pend_off    <= cfg_offset;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= '{valid: pix_valid_in, sof: pix_valid_in && pix_sof_in};
      s2 <= s1;
    end
  end

  assign pix_valid_out = s2.valid;
  assign pix_sof_out   = s2.sof;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    channel_adjust #(
      .CH_W      (CH_W),
      .GAIN_W    (GAIN_W),
      .GAIN_FRAC (GAIN_FRAC),
      .OFF_W     (OFF_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .in_valid (pix_valid_in),
      .s1_valid (s1.valid),
      .pix      (pix_in[i*CH_W +: CH_W]),
      .gain     (use_gain),
      .offset   (use_off),
      .out      (pix_out[i*CH_W +: CH_W]),
      .clamped  (clamp_flags[i])
    );
  end

`ifdef SAT_STATS_EN
  logic [15:0] n_clamp;
  logic [15:0] sat_cnt;
  logic [16:0] sat_sum;

  always_comb begin
    n_clamp = '0;
    for (int i = 0; i < NCH; i++) n_clamp = n_clamp + 16'(clamp_flags[i]);
    sat_sum = {1'b0, sat_cnt} + {1'b0, n_clamp};
  end

  // The sof pixel's own clamps start the new frame's count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_cnt   <= '0;
      sat_count <= '0;
    end else if (s2.valid) begin
      if (s2.sof) begin
        sat_count <= sat_cnt;
        sat_cnt   <= n_clamp;
      end else begin
        sat_cnt <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end
    end
  end
`else
  logic unused_clamp_flags;
  assign unused_clamp_flags = ^clamp_flags;
`endif

endmodule

// File: tb/tb_color_adjust.sv
// Randomized scoreboard bench for color_adjust against an arithmetic reference model.
module tb_color_adjust;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] pix_in = '0;
  logic        pix_valid_in = 1'b0;
  logic        pix_sof_in = 1'b0;
  logic [7:0]  cfg_gain = '0;
  logic [8:0]  cfg_offset = '0;
  logic        cfg_wr = 1'b0;
  logic [23:0] pix_out;
  logic        pix_valid_out;
  logic        pix_sof_out;
  logic        cfg_pending;
`ifdef SAT_STATS_EN
  logic [15:0] sat_count;
`endif

  color_adjust dut (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix_in),
    .pix_valid_in  (pix_valid_in),
    .pix_sof_in    (pix_sof_in),
    .cfg_gain      (cfg_gain),
    .cfg_offset    (cfg_offset),
    .cfg_wr        (cfg_wr),
    .pix_out       (pix_out),
    .pix_valid_out (pix_valid_out),
    .pix_sof_out   (pix_sof_out),
    .cfg_pending   (cfg_pending)
`ifdef SAT_STATS_EN
    ,
    .sat_count     (sat_count)
`endif
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [24:0] exp_q[$];
  int          due_q[$];
  int          ncl_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  // reference model state
  int   m_gain = 4, m_off = 0, m_pgain = 4, m_poff = 0;
  logic m_pend = 1'b0;
  int   m_cnt = 0, m_sat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [23:0] ref_pix(input logic [23:0] p, input int g, input int o,
                                          output int n);
    logic [23:0] res;
    res = '0;
    n = 0;
    for (int c = 0; c < 3; c++) begin
      int v, r;
      v = int'(p[c*8 +: 8]);
      r = (v * g) / 4 + o;
      if (r < 0) begin r = 0; n++; end
      else if (r > 255) begin r = 255; n++; end
      res[c*8 +: 8] = 8'(r);
    end
    return res;
  endfunction

  // driver: one cycle of stimulus, model update and pending-flag check
  task automatic drive(input logic v, input logic [23:0] p, input logic sof,
                       input logic wr, input logic [7:0] g, input logic [8:0] o);
    logic        applied;
    logic [23:0] e;
    int          n;
    @(posedge clk); #1;
    check("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    pix_valid_in = v; pix_in = p; pix_sof_in = sof;
    cfg_wr = wr; cfg_gain = g; cfg_offset = o;
    applied = v && sof && m_pend;
    if (applied) begin
      m_gain = m_pgain;
      m_off  = m_poff;
    end
    if (v) begin
      e = ref_pix(p, m_gain, m_off, n);
      exp_q.push_back({v && sof, e});
      due_q.push_back(cyc + 2);
      ncl_q.push_back(n);
    end
    if (wr) begin
      m_pgain = int'(g);
      m_poff  = int'($signed(o));
      m_pend  = 1'b1;
    end else if (applied) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 24'h0, 1'b0, 1'b0, 8'h0, 9'h0);
  endtask

  // reset, optionally with a valid pixel presented in the reset cycle
  task automatic do_reset(input logic with_pix, input logic [23:0] p);
    @(posedge clk); #1;
    reset = 1'b1; pix_valid_in = with_pix; pix_in = p; pix_sof_in = 1'b0; cfg_wr = 1'b0;
    exp_q.delete(); due_q.delete(); ncl_q.delete();
    m_gain = 4; m_off = 0; m_pgain = 4; m_poff = 0; m_pend = 1'b0;
    @(posedge clk); #1;
    pix_valid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_pix_out", 32'(pix_out), 32'h0);
    check("reset_valid", 32'(pix_valid_out), 32'h0);
    check("reset_sof", 32'(pix_sof_out), 32'h0);
    check("reset_cfg_pending", 32'(cfg_pending), 32'h0);
  endtask

  // monitor: every output cycle is compared against the queue head
  always @(negedge clk) begin
    logic        exp_valid;
    logic [24:0] e;
    int          n;
    if (reset) begin
      m_cnt = 0;
      m_sat = 0;
    end else begin
`ifdef SAT_STATS_EN
      check("sat_count", 32'(sat_count), 32'(m_sat));
`endif
      exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
      check("pix_valid_out", 32'(pix_valid_out), 32'(exp_valid));
      if (exp_valid) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        n = ncl_q.pop_front();
        check("pix_out", 32'(pix_out), 32'(e[23:0]));
        check("pix_sof_out", 32'(pix_sof_out), 32'(e[24]));
        if (e[24]) begin
          m_sat = m_cnt;
          m_cnt = n;
        end else begin
          m_cnt = (m_cnt + n > 65535) ? 65535 : m_cnt + n;
        end
      end
    end
  end

  initial begin
    do_reset(1'b0, 24'h0);

    // unity pass-through
    drive(1'b1, 24'h102030, 1'b0, 1'b0, 8'h0, 9'h0);
    // gain 6 / offset 16 applied at sof: expect 0xFF1F10
    drive(1'b0, 24'h0, 1'b0, 1'b1, 8'd6, 9'd16);
    drive(1'b1, 24'hC80A00, 1'b1, 1'b0, 8'h0, 9'h0);
    // gain 4 / offset -32: expect 0x004412
    drive(1'b0, 24'h0, 1'b0, 1'b1, 8'd4, 9'h1E0);
    drive(1'b1, 24'h146432, 1'b1, 1'b0, 8'h0, 9'h0);
    // mid-frame write waits for the next sof: 0x010101 -> 0x020202
    drive(1'b1, 24'h101010, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b1, 24'h505050, 1'b0, 1'b1, 8'd8, 9'd0);
    drive(1'b1, 24'h202020, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b1, 24'h010101, 1'b1, 1'b0, 8'h0, 9'h0);
    // valid gaps 1,0,1,1
    drive(1'b1, 24'h0A0B0C, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b0, 24'hFFFFFF, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b1, 24'h112233, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b1, 24'h445566, 1'b0, 1'b0, 8'h0, 9'h0);
    idle(3);
    // reset with two pixels in flight, then unity gain again
    drive(1'b1, 24'h808080, 1'b0, 1'b0, 8'h0, 9'h0);
    do_reset(1'b1, 24'h909090);
    idle(4);
    drive(1'b1, 24'h102030, 1'b1, 1'b0, 8'h0, 9'h0);
    idle(3);

    // saturation frame: 4 pixels of 0xC8C8C8 at gain 6 / offset 16
    drive(1'b0, 24'h0, 1'b0, 1'b1, 8'd6, 9'd16);
    drive(1'b1, 24'hC8C8C8, 1'b1, 1'b0, 8'h0, 9'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 24'hC8C8C8, 1'b0, 1'b0, 8'h0, 9'h0);
    drive(1'b1, 24'h000000, 1'b1, 1'b0, 8'h0, 9'h0);
    idle(3);
`ifdef SAT_STATS_EN
    check("sat_count_frame", 32'(sat_count), 32'd12);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 24'($urandom), $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)),
            9'($urandom_range(0, 511)));
    end
    idle(5);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
